// File: rtl/if_id_ctrl_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// FSM encoding, fixed instruction encodings and the opcode field slice.
package if_id_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      FLUSH  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [15:0] NOP_INS   = 16'h0800;
   localparam logic [4:0]  HALT_OP   = 5'b00000;
   localparam int          MAX_STALL = 8;
   localparam int          OPC_HI    = 15;
   localparam int          OPC_LO    = 11;

   function automatic logic [4:0] opcode(input logic [15:0] ins);
      return ins[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/if_id_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + ONE;
   end

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID register with stall/flush/HALT front-end control.
// Optional perf counters built when IF_ID_PERF_CNT_EN is defined.
module if_id_ctrl
   import if_id_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ins_IF,
   input  logic [15:0] inc_pc_IF,
   input  logic        stall_decode,
   input  logic        flush_fetch,
   output logic [15:0] ins_ID,
   output logic [15:0] inc_pc_ID,
   output logic        valid_ID,
   output logic        pc_write_en,
   output logic        idex_bubble,
   output logic        halted,
   output logic        stall_timeout,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_cycles
);

   state_t     state;
   logic       act_flush;
   logic       act_hold;
   logic       act_stall;
   logic       act_hdet;
   logic       act_adv;
   logic [7:0] run_cnt;

   // One-hot action select in priority order
   always_comb begin
      act_flush = 1'b0;
      act_hold  = 1'b0;
      act_stall = 1'b0;
      act_hdet  = 1'b0;
      act_adv   = 1'b0;
      if (rst) begin
      end else if (flush_fetch && state != HALTED) begin
         act_flush = 1'b1;
      end else if (state == HALTED) begin
         act_hold = 1'b1;
      end else if (stall_decode) begin
         act_stall = 1'b1;
      end else if (valid_ID && opcode(ins_ID) == HALT_OP) begin
         act_hdet = 1'b1;
      end else begin
         act_adv = 1'b1;
      end
   end

   assign pc_write_en = act_flush | act_adv;
   assign idex_bubble = act_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         ins_ID        <= NOP_INS;
         inc_pc_ID     <= '0;
         valid_ID      <= 1'b0;
         halted        <= 1'b0;
         stall_timeout <= 1'b0;
      end else if (act_flush) begin
         state     <= FLUSH;
         ins_ID    <= NOP_INS;
         inc_pc_ID <= '0;
         valid_ID  <= 1'b0;
      end else if (act_hold) begin
         state <= HALTED;
      end else if (act_stall) begin
         state <= STALL;
         if (run_cnt >= 8'(MAX_STALL - 1))
            stall_timeout <= 1'b1;
      end else if (act_hdet) begin
         state  <= HALTED;
         halted <= 1'b1;
      end else if (act_adv) begin
         state     <= RUN;
         ins_ID    <= ins_IF;
         inc_pc_ID <= inc_pc_IF;
         valid_ID  <= 1'b1;
      end
   end

   sat_counter #(.W(8)) u_run (
      .clk (clk),
      .clr (rst | ~act_stall),
      .inc (act_stall),
      .q   (run_cnt)
   );

`ifdef IF_ID_PERF_CNT_EN
   sat_counter #(.W(16)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (idex_bubble),
      .q   (stall_cycles)
   );

   sat_counter #(.W(16)) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (act_flush),
      .q   (flush_cycles)
   );
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Self-checking bench for if_id_ctrl: per-cycle model compare
// plus hand-computed literal expectations.
module tb_if_id_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ins_IF = 16'h0;
   logic [15:0] inc_pc_IF = 16'h0;
   logic        stall_decode = 1'b0;
   logic        flush_fetch = 1'b0;
   logic [15:0] ins_ID;
   logic [15:0] inc_pc_ID;
   logic        valid_ID;
   logic        pc_write_en;
   logic        idex_bubble;
   logic        halted;
   logic        stall_timeout;
   logic [15:0] stall_cycles;
   logic [15:0] flush_cycles;

`ifdef IF_ID_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   if_id_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ins_IF        (ins_IF),
      .inc_pc_IF     (inc_pc_IF),
      .stall_decode  (stall_decode),
      .flush_fetch   (flush_fetch),
      .ins_ID        (ins_ID),
      .inc_pc_ID     (inc_pc_ID),
      .valid_ID      (valid_ID),
      .pc_write_en   (pc_write_en),
      .idex_bubble   (idex_bubble),
      .halted        (halted),
      .stall_timeout (stall_timeout),
      .stall_cycles  (stall_cycles),
      .flush_cycles  (flush_cycles)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [15:0] m_ins, m_pc;
   bit          m_valid, m_halted, m_to, m_init;
   int          m_run, m_sc, m_fc;
   bit          e_pwe, e_bub;

   task automatic chk(input string n, input logic [15:0] a,
                      input logic [15:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask

   // Apply the spec's rules to this cycle: expected combinational
   // outputs now, registered state after the coming edge.
   task automatic model_step();
      e_pwe = 0;
      e_bub = 0;
      if (rst) begin
         m_ins = 16'h0800; m_pc = 0; m_valid = 0;
         m_halted = 0; m_to = 0; m_run = 0;
         m_sc = 0; m_fc = 0; m_init = 1;
      end else if (flush_fetch && !m_halted) begin
         e_pwe = 1;
         m_ins = 16'h0800; m_pc = 0; m_valid = 0;
         m_run = 0;
         if (m_fc < 65535) m_fc++;
      end else if (m_halted) begin
         m_run = 0;
      end else if (stall_decode) begin
         e_bub = 1;
         if (m_run < 255) m_run++;
         if (m_run >= 8) m_to = 1;
         if (m_sc < 65535) m_sc++;
      end else if (m_valid && (m_ins >> 11) == 0) begin
         m_halted = 1;
         m_run = 0;
      end else begin
         e_pwe = 1;
         m_ins = ins_IF; m_pc = inc_pc_IF; m_valid = 1;
         m_run = 0;
      end
   endtask

   task automatic cyc(input bit r, input logic [15:0] i,
                      input logic [15:0] p, input bit s, input bit f);
      @(negedge clk);
      rst = r; ins_IF = i; inc_pc_IF = p;
      stall_decode = s; flush_fetch = f;
      #1;
      // registered outputs reflect the model before this cycle's edge
      if (m_init) begin
         chk("ins_ID", ins_ID, m_ins);
         chk("inc_pc_ID", inc_pc_ID, m_pc);
         chk("valid_ID", 16'(valid_ID), 16'(m_valid));
         chk("halted", 16'(halted), 16'(m_halted));
         chk("stall_timeout", 16'(stall_timeout), 16'(m_to));
         chk("stall_cycles", stall_cycles, PERF ? 16'(m_sc) : 16'h0);
         chk("flush_cycles", flush_cycles, PERF ? 16'(m_fc) : 16'h0);
      end
      model_step();
      chk("pc_write_en", 16'(pc_write_en), 16'(e_pwe));
      chk("idex_bubble", 16'(idex_bubble), 16'(e_bub));
   endtask

   initial begin
      m_init = 0;
      m_ins = 0; m_pc = 0; m_valid = 0; m_halted = 0; m_to = 0;
      m_run = 0; m_sc = 0; m_fc = 0;

      cyc(1, 16'hC105, 16'h0002, 0, 0);
      cyc(1, 16'hC105, 16'h0002, 0, 0);
      chk("lit_rst_pwe", 16'(pc_write_en), 16'h0);
      chk("lit_rst_ins", ins_ID, 16'h0800);
      chk("lit_rst_valid", 16'(valid_ID), 16'h0);

      cyc(0, 16'hC105, 16'h0002, 0, 0);
      chk("lit_rel_ins", ins_ID, 16'h0800);
      cyc(0, 16'hC207, 16'h0004, 1, 0);
      chk("lit_first_ins", ins_ID, 16'hC105);
      chk("lit_stall_bub", 16'(idex_bubble), 16'h1);
      chk("lit_stall_pwe", 16'(pc_write_en), 16'h0);
      cyc(0, 16'hC207, 16'h0004, 1, 0);
      cyc(0, 16'hC207, 16'h0004, 1, 0);
      chk("lit_stall_hold", ins_ID, 16'hC105);
      cyc(0, 16'hC207, 16'h0004, 0, 0);
      chk("lit_stall_after", ins_ID, 16'hC105);
      chk("lit_stall_cnt", stall_cycles, PERF ? 16'd3 : 16'd0);

      cyc(0, 16'hC309, 16'h0006, 1, 1);
      chk("lit_fl_pwe", 16'(pc_write_en), 16'h1);
      chk("lit_fl_bub", 16'(idex_bubble), 16'h0);
      cyc(0, 16'hC309, 16'h0006, 0, 0);
      chk("lit_fl_ins", ins_ID, 16'h0800);
      chk("lit_fl_valid", 16'(valid_ID), 16'h0);
      chk("lit_fl_pc", inc_pc_ID, 16'h0);
      chk("lit_fl_cnt", flush_cycles, PERF ? 16'd1 : 16'd0);

      for (int k = 0; k < 7; k++) cyc(0, 16'hC40B, 16'h0008, 1, 0);
      cyc(0, 16'hC40B, 16'h0008, 0, 0);
      chk("lit_to7", 16'(stall_timeout), 16'h0);
      for (int k = 0; k < 8; k++) begin
         cyc(0, 16'hC50D, 16'h000A, 1, 0);
         if (k == 7) chk("lit_to8_pre", 16'(stall_timeout), 16'h0);
      end
      cyc(0, 16'hC50D, 16'h000A, 0, 0);
      chk("lit_to8", 16'(stall_timeout), 16'h1);
      cyc(0, 16'h6A11, 16'h000C, 0, 0);
      cyc(0, 16'h1234, 16'h000E, 0, 0);
      chk("lit_to_sticky", 16'(stall_timeout), 16'h1);
      cyc(0, 16'h9ABC, 16'h0010, 1, 0);
      cyc(0, 16'h9ABC, 16'h0010, 0, 0);

      cyc(0, 16'h0000, 16'h0020, 0, 0);
      cyc(0, 16'hC611, 16'h0022, 0, 0);
      chk("lit_hdet_ins", ins_ID, 16'h0000);
      chk("lit_hdet_pwe", 16'(pc_write_en), 16'h0);
      chk("lit_hdet_bub", 16'(idex_bubble), 16'h0);
      cyc(0, 16'hC611, 16'h0022, 1, 0);
      chk("lit_halted", 16'(halted), 16'h1);
      chk("lit_halt_pwe", 16'(pc_write_en), 16'h0);
      cyc(0, 16'hC611, 16'h0022, 0, 1);
      chk("lit_halt_flush_pwe", 16'(pc_write_en), 16'h0);
      cyc(0, 16'hC611, 16'h0022, 0, 0);
      chk("lit_halt_hold", ins_ID, 16'h0000);
      chk("lit_halt_still", 16'(halted), 16'h1);
      cyc(1, 16'hC611, 16'h0022, 0, 0);
      cyc(0, 16'hC713, 16'h0024, 0, 0);
      chk("lit_unhalt", 16'(halted), 16'h0);
      chk("lit_unhalt_to", 16'(stall_timeout), 16'h0);

      cyc(0, 16'hC815, 16'h0026, 1, 0);
      cyc(0, 16'hC815, 16'h0026, 1, 0);
      cyc(1, 16'hC815, 16'h0026, 1, 0);
      cyc(0, 16'hC917, 16'h0028, 0, 1);
      cyc(0, 16'hC917, 16'h0028, 0, 0);
      cyc(0, 16'hCA19, 16'h002A, 0, 0);
      cyc(0, 16'hCB1B, 16'h002C, 0, 0);
      chk("lit_end_ins", ins_ID, 16'hCA19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
